// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multicycle sequencer.
//   state_t  - FSM state encoding (also exported on the debug state port)
//   iclass_t - instruction class produced by ctrl_decode
//   OP_*     - recognised opcode values (instruction[31:26])
//   ALU_*    - alu_op encodings driven to the ALU control
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    IC_R    = 3'd0,
    IC_LW   = 3'd1,
    IC_SW   = 3'd2,
    IC_BEQ  = 3'd3,
    IC_ADDI = 3'd4,
    IC_ILL  = 3'd5
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode classifier.
//   op_i     [5:0] latched opcode (op_q of the sequencer)
//   iclass_o       instruction class; IC_ILL for anything unrecognised
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  output iclass_t    iclass_o
);

  always_comb begin
    case (op_i)
      OP_RTYPE: iclass_o = IC_R;
      OP_LW:    iclass_o = IC_LW;
      OP_SW:    iclass_o = IC_SW;
      OP_BEQ:   iclass_o = IC_BEQ;
      OP_ADDI:  iclass_o = IC_ADDI;
      default:  iclass_o = IC_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: opcode-driven multicycle sequencer for the single-issue
// datapath. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB as
// needed, stalls in MEM until mem_ready, and drives all datapath strobes.
//   clk, nreset      clock; synchronous active-low reset
//   run              allow a new fetch (sampled only in FETCH)
//   opcode [5:0]     instruction[31:26], latched into op_q in FETCH
//   zero             ALU zero flag, used by BEQ in EXEC
//   mem_ready        data memory completes access (only looked at in MEM)
//   ir_load .. reg_write  datapath control strobes
//   trap             sticky illegal-opcode flag
//   state [2:0]      current FSM state, for debug
//   retired [CNT_W]  instructions completed since reset (wraps)
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  iclass_t          iclass;

  ctrl_decode u_decode (
    .op_i     (op_q),
    .iclass_o (iclass)
  );

  // Next-state logic and retire-event detection.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    trap_d  = trap_q;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (run) begin
          op_d    = opcode;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (iclass == IC_ILL) begin
          state_d = TRAP;
          trap_d  = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (iclass)
          IC_R, IC_ADDI: state_d = WB;
          IC_LW, IC_SW:  state_d = MEM;
          IC_BEQ: begin
            state_d = FETCH;
            retire  = 1'b1;
          end
          default: begin
            state_d = TRAP;
            trap_d  = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (iclass == IC_LW) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end
      end
      WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= FETCH;
      op_q      <= '0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  // Strobe decode from state_q/op_q; run and zero are the only raw inputs
  // that reach a strobe. Reset gates everything so an abandoned MEM access
  // cannot write while nreset is held.
  always_comb begin
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    if (nreset) begin
      case (state_q)
        FETCH: begin
          ir_load  = run;
          pc_write = run;
        end
        EXEC: begin
          case (iclass)
            IC_R: alu_op = ALU_FUNCT;
            IC_LW, IC_SW, IC_ADDI: alu_src = 1'b1;
            IC_BEQ: begin
              alu_op   = ALU_SUB;
              pc_write = zero;
              pc_src   = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_read  = (iclass == IC_LW);
          mem_write = (iclass == IC_SW);
        end
        WB: begin
          reg_write  = 1'b1;
          reg_dst    = (iclass == IC_R);
          mem_to_reg = (iclass == IC_LW);
        end
        default: ;
      endcase
    end
  end

  assign trap    = trap_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule
